// File: rtl/mnist_pkg.sv
// Shared constants and state encodings for the UART image receive path.
// The framer's header state is used only when IMG_RX_HEADER_EN is defined.
package mnist_pkg;

  localparam int IMG_PIXELS = 784;
  localparam logic [7:0] IMG_HDR_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  typedef enum logic {
    WAIT_HDR = 1'b0,
    RECV     = 1'b1
  } frm_state_e;

endpackage

// File: rtl/uart_img_rx_if.sv
// Pixel stream from the image receiver to the mnist input port.
// Handshake: dout_vld is a one-cycle qualifier with no backpressure; img_dout is valid
// while dout_vld is high and is held until the next pixel. frame_done only ever rises
// together with dout_vld; frame_err and busy are standalone status signals.
interface uart_img_rx_if;
  logic [7:0] img_dout;
  logic       dout_vld;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  modport master (output img_dout, dout_vld, frame_done, frame_err, busy);
  modport slave  (input  img_dout, dout_vld, frame_done, frame_err, busy);
endinterface

// File: rtl/uart_rx_core.sv
// UART 8N1 bit-level receiver: 2-FF synchroniser, baud counter and bit FSM.
// rx_vld / rx_ferr are combinational and high during the cycle ending at the stop sample.
module uart_rx_core
  import mnist_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_byte,
  output logic       rx_vld,
  output logic       rx_ferr,
  output logic       rx_idle,
  output rx_state_e  state_dbg
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  logic             sync1_q, sync2_q, prev_q;
  logic             armed_q, armed_d;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      armed_q <= armed_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    armed_d = armed_q;
    rx_vld  = 1'b0;
    rx_ferr = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        // After reset the line must read high for a full bit time before a start
        // edge is trusted, so a byte cut by reset is never picked up mid-stream.
        if (!armed_q) begin
          if (sync2_q) begin
            if (cnt_q == DIV_LAST) armed_d = 1'b1;
            else                   cnt_d   = cnt_q + 1'b1;
          end
        end else if (prev_q && !sync2_q) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = sync2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          rx_vld  = sync2_q;
          rx_ferr = !sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_byte   = shift_q;
  assign rx_idle   = (state_q == IDLE);
  assign state_dbg = state_q;

endmodule

// File: rtl/uart_img_rx.sv
// UART 8N1 receiver plus image framer streaming one pixel per dout_vld pulse.
// Optional feature macro: IMG_RX_HEADER_EN (frames must start with header byte 8'hA5).
module uart_img_rx #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int IMG_PIXELS  = mnist_pkg::IMG_PIXELS,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rxd,
  uart_img_rx_if.master         out_if,
  output mnist_pkg::rx_state_e  dbg_rx_state,
  output mnist_pkg::frm_state_e dbg_frm_state
);
  import mnist_pkg::*;

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int PIX_W    = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
  localparam int IDLE_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(IMG_PIXELS - 1);
  localparam logic [IDLE_W-1:0] TO_MAX   = IDLE_W'(TIMEOUT_CYC);

  logic [7:0]        rx_byte;
  logic              rx_vld, rx_ferr, rx_idle;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]        dout_q, dout_d;
  logic              vld_q, vld_d, done_q, done_d, err_q, err_d;
  logic              pix_ok, timeout_hit;
  frm_state_e        frm_q;

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_core (
    .clk       (clk),
    .rst       (rst),
    .uart_rxd  (uart_rxd),
    .rx_byte   (rx_byte),
    .rx_vld    (rx_vld),
    .rx_ferr   (rx_ferr),
    .rx_idle   (rx_idle),
    .state_dbg (dbg_rx_state)
  );

`ifdef IMG_RX_HEADER_EN
  frm_state_e frm_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frm_q <= WAIT_HDR;
    else     frm_q <= frm_d;
  end

  // Frame end and any abort send the framer back to hunting for the header.
  always_comb begin
    frm_d = frm_q;
    if (frm_q == WAIT_HDR) begin
      if (rx_vld && (rx_byte == IMG_HDR_BYTE)) frm_d = RECV;
    end else if ((pix_ok && (pix_cnt_q == PIX_LAST)) || rx_ferr || timeout_hit) begin
      frm_d = WAIT_HDR;
    end
  end
`else
  assign frm_q = RECV;
`endif

  assign pix_ok      = rx_vld && (frm_q == RECV);
  assign timeout_hit = (pix_cnt_q != '0) && (idle_cnt_q == TO_MAX);

  // A valid byte outranks a timeout landing in the same cycle; a framing error and a
  // timeout together still yield one frame_err pulse.
  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    idle_cnt_d = idle_cnt_q;
    dout_d     = dout_q;
    vld_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (pix_ok) begin
      vld_d      = 1'b1;
      dout_d     = rx_byte;
      idle_cnt_d = '0;
      if (pix_cnt_q == PIX_LAST) begin
        done_d    = 1'b1;
        pix_cnt_d = '0;
      end else begin
        pix_cnt_d = pix_cnt_q + 1'b1;
      end
    end else if (rx_ferr || timeout_hit) begin
      err_d      = 1'b1;
      pix_cnt_d  = '0;
      idle_cnt_d = '0;
    end else if (pix_cnt_q == '0) begin
      idle_cnt_d = '0;
    end else if (rx_idle && (idle_cnt_q != TO_MAX)) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt_q  <= '0;
      idle_cnt_q <= '0;
      dout_q     <= '0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pix_cnt_q  <= pix_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      dout_q     <= dout_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign out_if.img_dout   = dout_q;
  assign out_if.dout_vld   = vld_q;
  assign out_if.frame_done = done_q;
  assign out_if.frame_err  = err_q;
  assign out_if.busy       = (pix_cnt_q != '0);
  assign dbg_frm_state     = frm_q;

endmodule
